mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, 1-cycle-read-latency SRAM between the pipeline's instruction-fetch port and data-memory port. It grants one requester per cycle and tracks which port owns the read data returning next cycle. It holds the last read word per port so a stalled pipeline stage sees stable data, and reports per-port stall to the hazard logic. It sits between the pipeline core (IF stage, E/M-stage memory access) and the shared SRAM macro.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STREAK_MAX, 4, max consecutive DM grants while IF waits (guard only)
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- if_req  input  1  fetch request, held until granted
- if_addr  input  ADDR_W  fetch address
- if_gnt  output  1  fetch granted this cycle
- if_stall  output  1  if_req & ~if_gnt
- if_rvalid  output  1  fetch data valid this cycle
- if_rdata  output  DATA_W  fetch data; held between returns
- dm_req  input  1  data request, held until granted
- dm_we  input  DATA_W/8  byte write enables; 0 means read
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  write data
- dm_gnt  output  1  data access granted this cycle
- dm_stall  output  1  dm_req & ~dm_gnt
- dm_rvalid  output  1  data read valid this cycle
- dm_rdata  output  DATA_W  read data; held between returns
- mem_en  output  1  SRAM access strobe
- mem_we  output  DATA_W/8  SRAM byte write enables
- mem_addr  output  ADDR_W  SRAM address
- mem_wdata  output  DATA_W  SRAM write data
- mem_rdata  input  DATA_W  SRAM read data, valid the cycle after a read strobe

## Operation
- Arbitration is combinational within the cycle. The winner's address, write enables and write data drive mem_*. mem_en = if_gnt | dm_gnt. Both grants are never asserted together.
- Default priority: DM over IF, because DM is the older instruction.
- The return FSM is registered, with states IDLE, RET_IF and RET_DM.
  - An IF grant sets the next state to RET_IF.
  - A DM grant with dm_we == 0 sets the next state to RET_DM.
  - A DM write grant, or no grant, sets the next state to IDLE.
- In RET_IF, if_rvalid = 1 and if_rdata = mem_rdata, and mem_rdata is captured into if_hold. RET_DM is the same for the DM port with dm_hold.
- Outside a return, each rdata output shows its hold register.
- A write completes at grant. No rvalid is produced for a write.
- A new grant may issue in the same cycle a return is delivered, so the arbiter is fully pipelined at one access per cycle.
- The requester must keep address, write enables and write data stable while req is high and gnt is low. Dropping req before gnt is legal and withdraws the request.

## Timing
- Grant latency: 0 cycles (same cycle as req when the requester wins).
- Read latency: rvalid exactly 1 cycle after gnt.
- Reset values (rst low, asynchronous):
  - FSM in IDLE, if_hold/dm_hold = 0, streak counter = 0.
  - if_gnt/dm_gnt/mem_en = 0, forced low while in reset; mem_we = 0.
  - if_rvalid/dm_rvalid = 0.
- Reset asserted with a read in flight: the return is discarded and no rvalid is issued after reset releases.
- Simultaneous requests: exactly one grant, DM unless the guard forces IF. The loser's stall is 1.
- No requests: mem_en = 0 and mem_addr = 0.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A saturating counter (width clog2(STREAK_MAX+1)) increments on each DM grant while if_req = 1.
  - It clears on an IF grant or when if_req = 0.
  - When the counter == STREAK_MAX and if_req = 1, IF wins over DM.
- ARB_STARVE_GUARD_EN undefined: strict DM priority. The counter logic is absent.

## Structure
- Shared package: return-state enum (IDLE/RET_IF/RET_DM), ADDR_W/DATA_W defaults, byte-enable width constant.
- One sub-module: arb_grant_logic, the combinational winner select plus the guard counter, so the guard is verified in isolation. The FSM and hold registers stay in the top level.

## Test plan
- if_req=1, if_addr=0x0010, dm_req=0; mem_rdata=0x00A00093 next cycle -> if_gnt=1 in cycle 0; if_rvalid=1 and if_rdata=0x00A00093 in cycle 1; if_rdata stays 0x00A00093 afterwards.
- if_req and dm_req both 1, dm_we=0, dm_addr=0x0200 -> dm_gnt=1, if_stall=1, mem_addr=0x0200; next cycle if_gnt=1 and dm_rvalid=1.
- dm_we=4'b0011, dm_wdata=0x12345678, dm_addr=0x0104 -> mem_we=4'b0011 and mem_wdata=0x12345678 in the grant cycle; dm_rvalid=0 the next cycle; dm_rdata keeps its previous value.
- Guard compiled in, STREAK_MAX=4, if_req and dm_req held high for 6 cycles -> DM granted in cycles 0-3, IF in cycle 4, DM in cycle 5. Guard compiled out -> DM in all 6 cycles.
- Read granted, then rst pulled low mid-cycle before the return -> all outputs reset immediately; after release, no rvalid appears and both rdata outputs read 0.
- Back-to-back reads IF@0x0000 then DM@0x0300 -> one grant per cycle; rvalid alternates IF then DM, each carrying the matching mem_rdata.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types and defaults for the IF/DM single-port SRAM arbiter.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents:
//   ret_state_t      - owner of the SRAM read data returning next cycle
//   ADDR_W_DEF       - default byte address width
//   DATA_W_DEF       - default data width
//   BE_W_DEF         - default byte-enable width (DATA_W_DEF/8)
//   streak_cnt_w()   - width of a counter that must hold 0..max
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  // Who owns mem_rdata in the current cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RET_IF = 2'd1,
    RET_DM = 2'd2
  } ret_state_t;

  // Width needed to count from 0 up to and including max_val.
  function automatic int streak_cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_grant.sv
// Purpose: combinational IF/DM winner select, DM priority, optional IF starvation guard.
// Latency: 0 cycles; grants follow the requests within the same cycle.
// Backpressure: the losing requester simply sees no grant and must hold its request.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   defined   - a saturating streak counter tracks DM grants taken while IF waits;
//               once it reaches STREAK_MAX, IF wins the next contested cycle.
//   undefined - strict DM-over-IF priority, no state (clk/rst ports absent).
//
// Ports:
//   clk, rst  - clock and async active-low reset (guard build only)
//   if_req    - fetch request (already gated low during reset by the parent)
//   dm_req    - data request (already gated low during reset by the parent)
//   if_gnt    - fetch wins this cycle
//   dm_gnt    - data wins this cycle; never together with if_gnt
module arb_grant_logic
  import mem_port_arbiter_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
`ifdef ARB_STARVE_GUARD_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = streak_cnt_w(STREAK_MAX);
  localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(STREAK_MAX);

  logic [CNT_W-1:0] streak_cnt;
  logic             guard_hit;

  // IF has watched STREAK_MAX DM grants go by while it waited.
  assign guard_hit = if_req && (streak_cnt == STREAK_LIM);

  always_comb begin
    if_gnt = if_req && (!dm_req || guard_hit);
    dm_gnt = dm_req && !if_gnt;
  end

  // Streak only means anything while IF is actually waiting, so any cycle
  // without an IF request (or with an IF grant) restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      streak_cnt <= '0;
    end else if (dm_gnt && (streak_cnt != STREAK_LIM)) begin
      streak_cnt <= streak_cnt + CNT_W'(1);
    end
  end
`else
  // DM is the older instruction, so it always goes first.
  always_comb begin
    dm_gnt = dm_req;
    if_gnt = if_req && !dm_req;
  end
`endif

endmodule : arb_grant_logic

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one 1-cycle-latency single-port SRAM between IF and DM ports.
// Latency: grant in the request cycle; read data/rvalid exactly one cycle after grant.
// Backpressure: the loser of a cycle sees stall=1 and must hold req/addr/we/wdata.
//
// Optional feature macro: ARB_STARVE_GUARD_EN (IF starvation guard, see arb_grant_logic).
//
// Ports:
//   clk, rst                          - clock, async active-low reset
//   if_req/if_addr                    - fetch request and address
//   if_gnt/if_stall                   - fetch granted / fetch waiting
//   if_rvalid/if_rdata                - fetch return strobe / data (held between returns)
//   dm_req/dm_we/dm_addr/dm_wdata     - data request; dm_we==0 is a read
//   dm_gnt/dm_stall                   - data granted / data waiting
//   dm_rvalid/dm_rdata                - data read strobe / data (held between returns)
//   mem_en/mem_we/mem_addr/mem_wdata  - SRAM strobe and command of the winner
//   mem_rdata                         - SRAM read data, valid the cycle after a read strobe
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STREAK_MAX = 4,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              dm_req,
  input  logic [BE_W-1:0]   dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_stall,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,

  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  ret_state_t        state_q;
  ret_state_t        state_nxt;
  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] dm_hold;
  logic              if_req_live;
  logic              dm_req_live;

  // Gating the requests with reset keeps every grant (and so mem_en and
  // mem_we) low for as long as reset is asserted, not just after an edge.
  assign if_req_live = if_req && rst;
  assign dm_req_live = dm_req && rst;

  arb_grant_logic #(
    .STREAK_MAX (STREAK_MAX)
  ) u_grant (
`ifdef ARB_STARVE_GUARD_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .if_req (if_req_live),
    .dm_req (dm_req_live),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

  assign if_stall = if_req && !if_gnt;
  assign dm_stall = dm_req && !dm_gnt;

  // SRAM command mux. Idle cycles drive zeros so the macro pins are quiet.
  // Only DM can write, so IF accesses always present mem_we = 0.
  always_comb begin
    mem_en    = if_gnt || dm_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Return FSM: state names the owner of next cycle's mem_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A new grant is decoded independently of the current return, which is
  // what keeps the port fully pipelined at one access per cycle.
  always_comb begin
    state_nxt = IDLE;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = if_hold;
    dm_rdata  = dm_hold;

    if (if_gnt) begin
      state_nxt = RET_IF;
    end else if (dm_gnt && (dm_we == '0)) begin
      state_nxt = RET_DM;
    end

    case (state_q)
      RET_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      RET_DM: begin
        dm_rvalid = 1'b1;
        dm_rdata  = mem_rdata;
      end
      default: begin
      end
    endcase
  end

  // Hold registers give a stalled consumer stable data after the return cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_hold <= '0;
      dm_hold <= '0;
    end else begin
      if (state_q == RET_IF) if_hold <= mem_rdata;
      if (state_q == RET_DM) dm_hold <= mem_rdata;
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed self-checking bench for mem_port_arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_stall;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_stall;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp;
  int n_err;

  mem_port_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .STREAK_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_stall  (if_stall),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_stall  (dm_stall),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs change here, checks follow #2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected grant pattern for six contested cycles.
  logic [5:0] exp_dm_pat;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;

`ifdef ARB_STARVE_GUARD_EN
    exp_dm_pat = 6'b101111;  // bit i = DM wins cycle i; IF forced at cycle 4
`else
    exp_dm_pat = 6'b111111;
`endif

    // ---- reset state, grants forced low even with a request pending
    #2;
    if_req = 1'b1;
    dm_req = 1'b1;
    #1;
    check_eq("rst_if_gnt",    32'(if_gnt),    32'd0);
    check_eq("rst_dm_gnt",    32'(dm_gnt),    32'd0);
    check_eq("rst_mem_en",    32'(mem_en),    32'd0);
    check_eq("rst_mem_we",    32'(mem_we),    32'd0);
    check_eq("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_eq("rst_if_rdata",  if_rdata,       32'd0);
    check_eq("rst_dm_rdata",  dm_rdata,       32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    #9;
    rst = 1'b1;
    #2;
    check_eq("idle_mem_en",   32'(mem_en),   32'd0);
    check_eq("idle_mem_addr", 32'(mem_addr), 32'd0);

    // ---- single IF read, then hold
    tick();
    if_req  = 1'b1;
    if_addr = 16'h0010;
    #2;
    check_eq("if1_gnt",      32'(if_gnt),   32'd1);
    check_eq("if1_stall",    32'(if_stall), 32'd0);
    check_eq("if1_mem_en",   32'(mem_en),   32'd1);
    check_eq("if1_mem_addr", 32'(mem_addr), 32'h0010);
    check_eq("if1_mem_we",   32'(mem_we),   32'd0);
    tick();
    if_req    = 1'b0;
    mem_rdata = 32'h00A00093;
    #2;
    check_eq("if1_rvalid",    32'(if_rvalid), 32'd1);
    check_eq("if1_rdata",     if_rdata,       32'h00A00093);
    check_eq("if1_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_eq("if1_idle_en",   32'(mem_en),    32'd0);
    tick();
    mem_rdata = 32'hDEADBEEF;
    #2;
    check_eq("if1_hold_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("if1_hold_rdata",  if_rdata,       32'h00A00093);

    // ---- contested: DM wins, IF follows; returns overlap new grants
    tick();
    if_req  = 1'b1;
    if_addr = 16'h0020;
    dm_req  = 1'b1;
    dm_we   = 4'b0000;
    dm_addr = 16'h0200;
    #2;
    check_eq("both_dm_gnt",   32'(dm_gnt),   32'd1);
    check_eq("both_if_gnt",   32'(if_gnt),   32'd0);
    check_eq("both_if_stall", 32'(if_stall), 32'd1);
    check_eq("both_dm_stall", 32'(dm_stall), 32'd0);
    check_eq("both_mem_addr", 32'(mem_addr), 32'h0200);
    tick();
    dm_req    = 1'b0;
    mem_rdata = 32'h11112222;
    #2;
    check_eq("both2_if_gnt",    32'(if_gnt),    32'd1);
    check_eq("both2_mem_addr",  32'(mem_addr),  32'h0020);
    check_eq("both2_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check_eq("both2_dm_rdata",  dm_rdata,       32'h11112222);
    tick();
    if_req    = 1'b0;
    mem_rdata = 32'h33334444;
    #2;
    check_eq("both3_if_rvalid", 32'(if_rvalid), 32'd1);
    check_eq("both3_if_rdata",  if_rdata,       32'h33334444);
    check_eq("both3_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_eq("both3_dm_hold",   dm_rdata,       32'h11112222);

    // ---- DM partial write: no return, hold untouched
    tick();
    dm_req   = 1'b1;
    dm_we    = 4'b0011;
    dm_addr  = 16'h0104;
    dm_wdata = 32'h12345678;
    #2;
    check_eq("wr_dm_gnt",    32'(dm_gnt),   32'd1);
    check_eq("wr_mem_we",    32'(mem_we),   32'h3);
    check_eq("wr_mem_wdata", mem_wdata,     32'h12345678);
    check_eq("wr_mem_addr",  32'(mem_addr), 32'h0104);
    tick();
    dm_req    = 1'b0;
    dm_we     = 4'b0000;
    mem_rdata = 32'h55555555;
    #2;
    check_eq("wr_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_eq("wr_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("wr_dm_rdata",  dm_rdata,       32'h11112222);

    // ---- six contested cycles: starvation guard behaviour
    tick();
    if_req  = 1'b1;
    if_addr = 16'h0040;
    dm_req  = 1'b1;
    dm_addr = 16'h0240;
    for (int i = 0; i < 6; i++) begin
      mem_rdata = 32'h100 + 32'(i);
      #2;
      check_eq($sformatf("streak%0d_dm_gnt", i), 32'(dm_gnt), 32'(exp_dm_pat[i]));
      check_eq($sformatf("streak%0d_if_gnt", i), 32'(if_gnt), 32'(!exp_dm_pat[i]));
      tick();
    end
    if_req    = 1'b0;
    dm_req    = 1'b0;
    mem_rdata = 32'h00000077;
    #2;
    check_eq("streak_end_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check_eq("streak_end_dm_rdata",  dm_rdata,       32'h00000077);

    // ---- reset with an IF read in flight
    tick();
    if_req  = 1'b1;
    if_addr = 16'h0080;
    #2;
    check_eq("rif_gnt", 32'(if_gnt), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rif_gnt_low",   32'(if_gnt),    32'd0);
    check_eq("rif_mem_en",    32'(mem_en),    32'd0);
    check_eq("rif_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("rif_if_rdata",  if_rdata,       32'd0);
    check_eq("rif_dm_rdata",  dm_rdata,       32'd0);
    if_req = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    tick();
    mem_rdata = 32'h99999999;
    #2;
    check_eq("rif_post_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("rif_post_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_eq("rif_post_if_rdata",  if_rdata,       32'd0);
    check_eq("rif_post_dm_rdata",  dm_rdata,       32'd0);

    // ---- back-to-back IF then DM reads
    tick();
    if_req  = 1'b1;
    if_addr = 16'h0000;
    #2;
    check_eq("b2b_if_gnt",   32'(if_gnt),   32'd1);
    check_eq("b2b_dm_gnt0",  32'(dm_gnt),   32'd0);
    check_eq("b2b_addr0",    32'(mem_addr), 32'h0000);
    check_eq("b2b_en0",      32'(mem_en),   32'd1);
    tick();
    if_req    = 1'b0;
    dm_req    = 1'b1;
    dm_we     = 4'b0000;
    dm_addr   = 16'h0300;
    mem_rdata = 32'hAAAA0000;
    #2;
    check_eq("b2b_dm_gnt",     32'(dm_gnt),    32'd1);
    check_eq("b2b_if_gnt1",    32'(if_gnt),    32'd0);
    check_eq("b2b_addr1",      32'(mem_addr),  32'h0300);
    check_eq("b2b_if_rvalid",  32'(if_rvalid), 32'd1);
    check_eq("b2b_if_rdata",   if_rdata,       32'hAAAA0000);
    check_eq("b2b_dm_rvalid0", 32'(dm_rvalid), 32'd0);
    tick();
    dm_req    = 1'b0;
    mem_rdata = 32'hBBBB0300;
    #2;
    check_eq("b2b_dm_rvalid",  32'(dm_rvalid), 32'd1);
    check_eq("b2b_dm_rdata",   dm_rdata,       32'hBBBB0300);
    check_eq("b2b_if_rvalid1", 32'(if_rvalid), 32'd0);
    check_eq("b2b_if_hold",    if_rdata,       32'hAAAA0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_port_arbiter
